// File: rtl/if_fetch_pkg.sv
// Shared bus constants for the instruction-fetch slice.
// Holds the register-bus width, the zero word, reset and flush levels, and the PC step.
package if_fetch_pkg;
  localparam int unsigned RegWidth = 32;
  typedef logic [RegWidth-1:0] reg_bus_t;

  localparam reg_bus_t ZeroWord    = '0;
  localparam reg_bus_t PcStep      = 32'd4;
  localparam reg_bus_t AlignMask   = 32'hFFFF_FFFC;
  localparam logic     RstEnable   = 1'b0;
  localparam logic     FlushEnable = 1'b1;
endpackage

// File: rtl/if_inst_fifo.sv
// Two-entry instruction queue with push, pop and clear.
// Clear has priority over push and pop.
module if_inst_fifo
  import if_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [RegWidth-1:0] din,
  output logic [RegWidth-1:0] head,
  output logic [1:0]          count,
  output logic                empty,
  output logic                full
);
  logic [RegWidth-1:0] mem [2];
  logic                wr_ptr, rd_ptr;
  logic                do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!clear && do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: sequential PC generation, up to two fetches in flight,
// in-order response buffering, and flush/redirect with discard of stale responses.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [RegWidth-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned         DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [RegWidth-1:0] redirect_pc,
  output logic                imem_req,
  output logic [RegWidth-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [RegWidth-1:0] imem_rdata,
  output logic                if_valid,
  output logic [RegWidth-1:0] if_pc,
  output logic [RegWidth-1:0] if_inst
);
  logic [RegWidth-1:0] fetch_pc, deliver_pc, target;
  logic [1:0]          out_cnt, drop_cnt, q_count;
  logic [RegWidth-1:0] q_head;
  logic                q_empty, q_full;
  logic                do_flush, rv_ok, grant, push, pop;
  logic [2:0]          occupancy;

  assign do_flush  = (flush == FlushEnable);
  assign target    = redirect_pc & AlignMask;
  assign rv_ok     = imem_rvalid && (out_cnt != 2'd0);
  assign pop       = !q_empty && !stall && !do_flush;
  assign push      = !do_flush && rv_ok && (drop_cnt == 2'd0);
  assign occupancy = {1'b0, out_cnt} + {1'b0, q_count} - {2'b00, pop};

  // Gated by reset so the request line reads low while reset is held.
  assign imem_req  = (rst != RstEnable) && !do_flush && (occupancy < 3'(DEPTH));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  assign if_valid  = !q_empty;
  assign if_pc     = q_empty ? ZeroWord : deliver_pc;
  assign if_inst   = q_empty ? ZeroWord : q_head;

  if_inst_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (do_flush),
    .push  (push),
    .pop   (pop),
    .din   (imem_rdata),
    .head  (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      fetch_pc   <= RESET_PC;
      deliver_pc <= RESET_PC;
      out_cnt    <= 2'd0;
      drop_cnt   <= 2'd0;
    end else begin
      out_cnt <= out_cnt + {1'b0, grant} - {1'b0, rv_ok};
      if (do_flush) begin
        fetch_pc   <= target;
        deliver_pc <= target;
        // Everything still outstanding after this cycle belongs to a dead stream.
        drop_cnt   <= out_cnt - {1'b0, rv_ok};
      end else begin
        if (grant) fetch_pc <= fetch_pc + PcStep;
        if (pop) deliver_pc <= deliver_pc + PcStep;
        if (rv_ok && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst != RstEnable && imem_rvalid) assert (out_cnt != 2'd0);
    if (rst != RstEnable && push && !pop) assert (!q_full);
  end
endmodule
